// File: rtl/ps_level_sequencer.sv
// Timed proximity-sensor sequencer: periodic req/ack sampling, 2^AVG_LOG2 averaging,
// thermometer bar level with downward hysteresis and a decaying peak-hold.
module ps_level_sequencer #(
    parameter int unsigned PERIOD_CYC  = 500000,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned AVG_LOG2    = 2,
    parameter logic [17:0] THRESH_LO   = 18'h00200,
    parameter logic [17:0] STEP        = 18'h007C0,
    parameter logic [17:0] HYST        = 18'h00040,
    parameter int unsigned HOLD_UPD    = 25
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        meas_req,
    input  logic        meas_ack,
    input  logic [17:0] ps_data,
    input  logic        ps_err,
    output logic [17:0] avg_data,
    output logic        avg_valid,
    output logic [7:0]  level,
    output logic [7:0]  peak,
    output logic [7:0]  err_cnt,
    output logic        overrun,
    output logic        busy
);

    localparam int unsigned AW    = 18 + AVG_LOG2;
    localparam int unsigned CW    = AVG_LOG2 + 1;
    localparam int unsigned NSAMP = 1 << AVG_LOG2;
    localparam int unsigned TW    = $clog2(PERIOD_CYC + 1);
    localparam int unsigned OW    = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned HW    = (HOLD_UPD > 0) ? $clog2(HOLD_UPD + 1) : 1;

    typedef enum logic [2:0] {StIdle, StWait, StReq, StAcc, StUpd} state_e;

    state_e          state;
    logic [TW-1:0]   timer;
    logic [OW-1:0]   tout;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [HW-1:0]   hold;
    logic            enable_q;
    logic            tick;

    logic [17:0]     avg;
    logic [3:0]      raw_k, cur_k, new_k;
    logic [7:0]      new_level, peak_n;
    logic [HW-1:0]   hold_n;
    logic [7:0]      err_inc;

    function automatic logic [17:0] thr(input int i);
        return THRESH_LO + STEP * 18'(i);
    endfunction

    assign tick    = enable && (timer == TW'(PERIOD_CYC - 1));
    assign busy    = (state != StIdle);
    assign err_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (!enable || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // Level/peak candidates are evaluated while in ACC and registered on entry to UPD.
    always_comb begin
        avg   = acc[AW-1:AVG_LOG2];
        raw_k = '0;
        cur_k = '0;
        for (int i = 0; i < 8; i++) begin
            if (avg >= thr(i)) raw_k = raw_k + 4'd1;
            if (level[i])      cur_k = cur_k + 4'd1;
        end
        if (raw_k >= cur_k) begin
            new_k = raw_k;
        end else if (avg < thr(int'(cur_k) - 1) - HYST) begin
            new_k = raw_k;
        end else begin
            new_k = cur_k;
        end
        new_level = 8'hFF >> (4'd8 - new_k);
        peak_n    = peak;
        hold_n    = hold;
        if (new_level >= peak) begin
            peak_n = new_level;
            hold_n = HW'(HOLD_UPD);
        end else if (hold != '0) begin
            hold_n = hold - HW'(1);
        end else begin
            peak_n = ((peak >> 1) > new_level) ? (peak >> 1) : new_level;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            meas_req  <= 1'b0;
            tout      <= '0;
            acc       <= '0;
            cnt       <= '0;
            hold      <= '0;
            enable_q  <= 1'b0;
            avg_data  <= '0;
            avg_valid <= 1'b0;
            level     <= '0;
            peak      <= '0;
            err_cnt   <= '0;
            overrun   <= 1'b0;
        end else begin
            enable_q  <= enable;
            avg_valid <= 1'b0;
            if (enable_q && !enable) begin
                overrun <= 1'b0;
            end else if (tick && (state == StReq || state == StAcc || state == StUpd)) begin
                overrun <= 1'b1;
            end

            if (!enable) begin
                state    <= StIdle;
                meas_req <= 1'b0;
                tout     <= '0;
                acc      <= '0;
                cnt      <= '0;
            end else begin
                unique case (state)
                    StIdle: state <= StWait;
                    StWait: begin
                        if (tick) begin
                            state    <= StReq;
                            meas_req <= 1'b1;
                            tout     <= '0;
                        end
                    end
                    StReq: begin
                        if (meas_ack) begin
                            meas_req <= 1'b0;
                            if (ps_err) begin
                                err_cnt <= err_inc;
                                state   <= StWait;
                            end else begin
                                acc   <= acc + AW'(ps_data);
                                cnt   <= cnt + CW'(1);
                                state <= StAcc;
                            end
                        end else if (tout == OW'(TIMEOUT_CYC - 1)) begin
                            meas_req <= 1'b0;
                            err_cnt  <= err_inc;
                            state    <= StWait;
                        end else begin
                            tout <= tout + OW'(1);
                        end
                    end
                    StAcc: begin
                        if (cnt == CW'(NSAMP)) begin
                            avg_data  <= avg;
                            level     <= new_level;
                            peak      <= peak_n;
                            hold      <= hold_n;
                            avg_valid <= 1'b1;
                            state     <= StUpd;
                        end else begin
                            state <= StWait;
                        end
                    end
                    StUpd: begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= StWait;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps_level_sequencer.sv
// Directed self-checking bench for ps_level_sequencer with short period/timeout/hold.
module tb_ps_level_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        meas_req;
    logic        meas_ack;
    logic [17:0] ps_data;
    logic        ps_err;
    logic [17:0] avg_data;
    logic        avg_valid;
    logic [7:0]  level;
    logic [7:0]  peak;
    logic [7:0]  err_cnt;
    logic        overrun;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    ps_level_sequencer #(
        .PERIOD_CYC (20),
        .TIMEOUT_CYC(8),
        .AVG_LOG2   (2),
        .HOLD_UPD   (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .meas_req (meas_req),
        .meas_ack (meas_ack),
        .ps_data  (ps_data),
        .ps_err   (ps_err),
        .avg_data (avg_data),
        .avg_valid(avg_valid),
        .level    (level),
        .peak     (peak),
        .err_cnt  (err_cnt),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!meas_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!meas_req) chk("req_wait_timeout", 32'(meas_req), 32'd1);
    endtask

    task automatic sample(input logic [17:0] d, input logic e);
        wait_req();
        ps_data  = d;
        ps_err   = e;
        meas_ack = 1'b1;
        @(negedge clk);
        meas_ack = 1'b0;
        ps_err   = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!avg_valid && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(avg_valid), 32'd1);
    endtask

    task automatic avg4(input string tag, input logic [17:0] d,
                        input logic [7:0] lv, input logic [7:0] pk);
        int n;
        repeat (4) sample(d, 1'b0);
        wait_valid(tag, n);
        chk({tag, "_avg"}, 32'(avg_data), 32'(d));
        chk({tag, "_level"}, 32'(level), 32'(lv));
        chk({tag, "_peak"}, 32'(peak), 32'(pk));
    endtask

    logic [7:0] pk_seq [9] = '{8'hFF, 8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

    initial begin
        int n;
        int h;
        reset_n  = 1'b0;
        enable   = 1'b0;
        meas_ack = 1'b0;
        ps_data  = '0;
        ps_err   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_req", 32'(meas_req), 32'd0);
        chk("rst_avg", 32'(avg_data), 32'd0);
        chk("rst_valid", 32'(avg_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_peak", 32'(peak), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // First request after PERIOD_CYC edges
        enable = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (meas_req) begin
                n = i;
                break;
            end
        end
        chk("first_req_delay", 32'(n), 32'd20);
        chk("busy_on", 32'(busy), 32'd1);
        @(negedge clk);

        // First average, with latency and single-cycle pulse
        repeat (4) sample(18'h00200, 1'b0);
        wait_valid("t2", n);
        chk("t2_latency", 32'(n), 32'd1);
        chk("t2_avg", 32'(avg_data), 32'h200);
        chk("t2_level", 32'(level), 32'h01);
        chk("t2_peak", 32'(peak), 32'h01);
        @(negedge clk);
        chk("t2_pulse_width", 32'(avg_valid), 32'd0);

        // Hysteresis from the top
        avg4("t3a", 18'h03840, 8'hFF, 8'hFF);
        avg4("t3b", 18'h0383F, 8'hFF, 8'hFF);
        avg4("t3c", 18'h03000, 8'h3F, 8'hFF);

        // Hysteresis from 7F; peak decays as hold expires
        avg4("t4a", 18'h03080, 8'h7F, 8'hFF);
        avg4("t4b", 18'h03050, 8'h7F, 8'h7F);
        avg4("t4c", 18'h0303F, 8'h3F, 8'h3F);

        // Timeout and error ack interleaved with a partial average
        sample(18'h01940, 1'b0);
        sample(18'h01940, 1'b0);
        wait_req();
        h = 0;
        while (meas_req && h < 20) begin
            h++;
            @(negedge clk);
        end
        chk("t5_req_high_cycles", 32'(h), 32'd8);
        chk("t5_err_timeout", 32'(err_cnt), 32'd1);
        sample(18'h3FFFF, 1'b1);
        chk("t5_err_ack", 32'(err_cnt), 32'd2);
        chk("t5_no_early_valid", 32'(avg_valid), 32'd0);
        sample(18'h01940, 1'b0);
        sample(18'h01940, 1'b0);
        wait_valid("t5", n);
        chk("t5_avg", 32'(avg_data), 32'h1940);
        chk("t5_level", 32'(level), 32'h0F);
        chk("t5_peak", 32'(peak), 32'h1F);

        // Peak-hold decay sequence
        avg4("t6_top", 18'h03840, 8'hFF, 8'hFF);
        for (int i = 0; i < 9; i++) begin
            avg4($sformatf("t6_decay%0d", i), 18'h00200, 8'h01, pk_seq[i]);
        end
        chk("t6_overrun", 32'(overrun), 32'd0);

        // Disable mid-request
        wait_req();
        enable = 1'b0;
        @(negedge clk);
        chk("dis_req", 32'(meas_req), 32'd0);
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_level", 32'(level), 32'h01);
        chk("dis_peak", 32'(peak), 32'h01);
        chk("dis_err", 32'(err_cnt), 32'd2);
        chk("dis_avg", 32'(avg_data), 32'h200);

        // Asynchronous reset mid-handshake
        enable = 1'b1;
        @(negedge clk);
        wait_req();
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_req", 32'(meas_req), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_err", 32'(err_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
